change_payout: RTL and testbench

//  Downstream stage of VendingMachine: consumes its single-cycle Change1/Change05 strobes,

---
 rtl/vm_pkg.sv | 10 +
 rtl/change_payout_timer.sv | 20 ++
 rtl/change_payout.sv | 101 ++++++++++
 tb/tb_change_payout.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: state encoding and coin values shared between VendingMachine and change_payout
package vm_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ1  = 3'd1;
  localparam logic [2:0] S_REQ05 = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
  localparam int VAL_1TL  = 2;
  localparam int VAL_05TL = 1;
endpackage

// File: rtl/change_payout_timer.sv
// payout_timer: counts cycles an eject request has waited; flags expiry at LIMIT
module payout_timer #(
  parameter int LIMIT = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(LIMIT);
  // restart on load, count while enabled and stop at the limit
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/change_payout.sv
// change_payout: accumulates change owed and pays it out coin by coin through a two-tube hopper
module change_payout
  import vm_pkg::*;
#(
  parameter int OWED_W      = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Change1,
  input  logic              Change05,
  input  logic              Empty1,
  input  logic              Empty05,
  input  logic              Hopper_Ack,
  input  logic              Clear,
  output logic              Eject1,
  output logic              Eject05,
  output logic [OWED_W-1:0] Owed,
  output logic              Busy,
  output logic              Stall,
  output logic              Done,
  output logic              Fault,
  output logic              OvfErr
);
  localparam int SW = OWED_W + 2;
  localparam logic [OWED_W-1:0] MAX = '1;
  logic [2:0] state_q, state_d;
  logic [OWED_W-1:0] owed_q, owed_d;
  logic [SW-1:0] add, sub, sum;
  logic eject1_q, eject05_q, done_q, done_d, fault_q, fault_d, ovf_q, ovf_d;
  logic in_req, ack_ok, can1, can05, sat, expired;
  assign in_req = state_q == S_REQ1 || state_q == S_REQ05;
  assign ack_ok = in_req && Hopper_Ack;
  assign add = (Change1 ? SW'(VAL_1TL) : '0) + (Change05 ? SW'(VAL_05TL) : '0);
  assign sub = !ack_ok ? '0 : state_q == S_REQ1 ? SW'(VAL_1TL) : SW'(VAL_05TL);
  assign sum = {2'b00, owed_q} + add - sub;
  assign sat = sum > {2'b00, MAX};
  assign owed_d = sat ? MAX : sum[OWED_W-1:0];
  assign ovf_d = sat || (ovf_q && !Clear);
  assign done_d = ack_ok && owed_d == '0;
  assign can1 = owed_q >= OWED_W'(VAL_1TL) && !Empty1;
  assign can05 = owed_q >= OWED_W'(VAL_05TL) && !Empty05;
  assign Owed = owed_q;
  assign Eject1 = eject1_q;
  assign Eject05 = eject05_q;
  assign Done = done_q;
  assign Fault = fault_q;
  assign OvfErr = ovf_q;
  assign Busy = state_q != S_IDLE;
  assign Stall = state_q == S_IDLE && owed_q != '0 && !can1 && !can05;
  payout_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load_i   (state_q == S_IDLE),
    .en_i     (in_req),
    .expired_o(expired)
  );
  // payout FSM: prefer 1 TL coins, never overpay, fault on a missing ack
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: state_d = can1 ? S_REQ1 : can05 ? S_REQ05 : S_IDLE;
      S_REQ1, S_REQ05: begin
        if (Hopper_Ack) state_d = S_REL;
        else if (expired) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
      end
      S_REL: state_d = Hopper_Ack ? S_REL : S_IDLE;
      S_FAULT: begin
        if (Clear && !Hopper_Ack) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state, owed accumulator and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      owed_q    <= '0;
      eject1_q  <= 1'b0;
      eject05_q <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owed_q    <= owed_d;
      eject1_q  <= state_d == S_REQ1;
      eject05_q <= state_d == S_REQ05;
      done_q    <= done_d;
      fault_q   <= fault_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_change_payout.sv
// tb_change_payout: directed scenario tests for change_payout
module tb_change_payout;
  logic Clk = 1'b0, Rst_n = 1'b0;
  logic Change1 = 1'b0, Change05 = 1'b0, Empty1 = 1'b0, Empty05 = 1'b0;
  logic Hopper_Ack = 1'b0, Clear = 1'b0;
  logic Eject1, Eject05, Busy, Stall, Done, Fault, OvfErr;
  logic [3:0] Owed;
  int total = 0, bad = 0;

  change_payout #(.OWED_W(4), .ACK_TIMEOUT(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Change1(Change1), .Change05(Change05),
    .Empty1(Empty1), .Empty05(Empty05), .Hopper_Ack(Hopper_Ack), .Clear(Clear),
    .Eject1(Eject1), .Eject05(Eject05), .Owed(Owed), .Busy(Busy), .Stall(Stall),
    .Done(Done), .Fault(Fault), .OvfErr(OvfErr)
  );

  always #5 Clk = ~Clk;

  task tick;
    @(posedge Clk);
    #1;
  endtask

  task wait_eject(output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (Eject1 || Eject05) ok = 1;
      else tick();
    end
  endtask

  task coin(input logic e1, input logic [3:0] owed_after, input logic done_exp);
    bit ok;
    wait_eject(ok);
    total++;
    if (!ok || Eject1 !== e1 || Eject05 !== !e1) begin
      bad++;
      $display("FAIL coin_req got e1=%b e05=%b want e1=%b e05=%b", Eject1, Eject05, e1, !e1);
    end
    tick();
    tick();
    Hopper_Ack = 1'b1;
    tick();
    total++;
    if (Owed !== owed_after || Done !== done_exp || Eject1 !== 1'b0 || Eject05 !== 1'b0) begin
      bad++;
      $display("FAIL coin_ack got owed=%0d done=%b e1=%b e05=%b want owed=%0d done=%b e=0",
               Owed, Done, Eject1, Eject05, owed_after, done_exp);
    end
    Hopper_Ack = 1'b0;
    tick();
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL coin_release got busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task test_reset;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    total++;
    if ({Eject1, Eject05, Owed, Busy, Stall, Done, Fault, OvfErr} !== 11'd0) begin
      bad++;
      $display("FAIL reset got e1=%b e05=%b owed=%0d busy=%b stall=%b done=%b fault=%b ovf=%b want all 0",
               Eject1, Eject05, Owed, Busy, Stall, Done, Fault, OvfErr);
    end
  endtask

  task test_single05;
    Change05 = 1'b1;
    tick();
    Change05 = 1'b0;
    total++;
    if (Owed !== 4'd1 || Eject05 !== 1'b0) begin
      bad++;
      $display("FAIL single05_owed got owed=%0d e05=%b want 1 0", Owed, Eject05);
    end
    tick();
    total++;
    if (Eject05 !== 1'b1 || Eject1 !== 1'b0 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL single05_latency got e05=%b e1=%b busy=%b want 1 0 1", Eject05, Eject1, Busy);
    end
    coin(1'b0, 4'd0, 1'b1);
  endtask

  task test_both;
    Change1 = 1'b1;
    Change05 = 1'b1;
    tick();
    Change1 = 1'b0;
    Change05 = 1'b0;
    total++;
    if (Owed !== 4'd3) begin
      bad++;
      $display("FAIL both_owed got %0d want 3", Owed);
    end
    coin(1'b1, 4'd1, 1'b0);
    coin(1'b0, 4'd0, 1'b1);
  endtask

  task test_empty;
    Empty1 = 1'b1;
    Change1 = 1'b1;
    tick();
    Change1 = 1'b0;
    coin(1'b0, 4'd1, 1'b0);
    coin(1'b0, 4'd0, 1'b1);
    Empty05 = 1'b1;
    Change05 = 1'b1;
    tick();
    Change05 = 1'b0;
    tick();
    tick();
    total++;
    if (Stall !== 1'b1 || Owed !== 4'd1 || Eject05 !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_both_empty got stall=%b owed=%0d e05=%b busy=%b want 1 1 0 0", Stall, Owed, Eject05, Busy);
    end
    Hopper_Ack = 1'b1;
    tick();
    Hopper_Ack = 1'b0;
    total++;
    if (Owed !== 4'd1) begin
      bad++;
      $display("FAIL idle_ack_ignored got owed=%0d want 1", Owed);
    end
    Empty1 = 1'b0;
    tick();
    tick();
    total++;
    if (Stall !== 1'b1 || Eject1 !== 1'b0) begin
      bad++;
      $display("FAIL no_overpay got stall=%b e1=%b want 1 0", Stall, Eject1);
    end
    Empty05 = 1'b0;
    coin(1'b0, 4'd0, 1'b1);
  endtask

  task test_timeout;
    bit ok;
    int n;
    Change1 = 1'b1;
    tick();
    Change1 = 1'b0;
    wait_eject(ok);
    total++;
    if (!ok || Eject1 !== 1'b1) begin
      bad++;
      $display("FAIL timeout_req got ok=%0d e1=%b want 1 1", ok, Eject1);
    end
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick();
      if (Fault) n = i;
    end
    total++;
    if (n !== 17 || Eject1 !== 1'b0 || Owed !== 4'd2 || Busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout got cycles=%0d e1=%b owed=%0d busy=%b want 17 0 2 1", n, Eject1, Owed, Busy);
    end
    tick();
    tick();
    total++;
    if (Fault !== 1'b1 || Eject1 !== 1'b0) begin
      bad++;
      $display("FAIL fault_hold got fault=%b e1=%b want 1 0", Fault, Eject1);
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    total++;
    if (Fault !== 1'b0 || Busy !== 1'b0 || Owed !== 4'd2) begin
      bad++;
      $display("FAIL fault_clear got fault=%b busy=%b owed=%0d want 0 0 2", Fault, Busy, Owed);
    end
    coin(1'b1, 4'd0, 1'b1);
  endtask

  task test_ovf;
    Empty1 = 1'b1;
    Empty05 = 1'b1;
    Change1 = 1'b1;
    Change05 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    Change1 = 1'b0;
    Change05 = 1'b0;
    total++;
    if (Owed !== 4'd15 || OvfErr !== 1'b1 || Stall !== 1'b1) begin
      bad++;
      $display("FAIL ovf got owed=%0d ovf=%b stall=%b want 15 1 1", Owed, OvfErr, Stall);
    end
    tick();
    total++;
    if (OvfErr !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got %b want 1", OvfErr);
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    total++;
    if (OvfErr !== 1'b0 || Owed !== 4'd15) begin
      bad++;
      $display("FAIL ovf_clear got ovf=%b owed=%0d want 0 15", OvfErr, Owed);
    end
  endtask

  task test_reset_mid;
    bit ok;
    test_reset();
    Empty1 = 1'b0;
    Empty05 = 1'b0;
    Change1 = 1'b1;
    tick();
    Change1 = 1'b0;
    wait_eject(ok);
    total++;
    if (!ok || Eject1 !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_req got ok=%0d e1=%b want 1 1", ok, Eject1);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    total++;
    if (Eject1 !== 1'b0 || Owed !== 4'd0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got e1=%b owed=%0d busy=%b want 0 0 0", Eject1, Owed, Busy);
    end
    tick();
    Rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (Eject1 !== 1'b0 || Owed !== 4'd0 || Busy !== 1'b0 || Stall !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after got e1=%b owed=%0d busy=%b stall=%b want 0 0 0 0", Eject1, Owed, Busy, Stall);
    end
  endtask

  initial begin
    test_reset();
    test_single05();
    test_both();
    test_empty();
    test_timeout();
    test_ovf();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
